// File: rtl/mlp_layer_ctrl.sv
// ----------------------------------------------------------------------------
// mlp_layer_ctrl
//   Sequencer for one MLP layer. On run_start it walks the input buffer
//   (1-cycle read latency) in lock-step with the layer weight memory. It
//   strobes layer_start / layer_valid / layer_relu_en and pulses done. Host
//   weight writes pass through to the layer only while the sequencer is idle.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   run_start                 request one inference pass (sampled in IDLE)
//   busy, done                run in progress / 1-cycle completion pulse
//   wgt_wr_req/data/row/col   host weight write request
//   wgt_wr_ready              high iff idle (combinational)
//   in_rd_addr                input-buffer read address
//   layer_wr_en/weight/row/col  gated weight write to the layer
//   layer_input_index         weight-memory column, equal to in_rd_addr
//   layer_start/valid/relu_en layer control strobes (mutually exclusive)
//   perf_cycles, perf_runs    performance counters
//
// Optional feature: define MLP_CTRL_PERF_EN to build the performance counters.
// Without it, perf_cycles and perf_runs are tied to zero.
// ----------------------------------------------------------------------------
module mlp_layer_ctrl #(
    parameter int unsigned N_INPUTS   = 2,
    parameter int unsigned N_NEURONS  = 4,
    parameter int unsigned WGT_WIDTH  = 16,
    parameter int unsigned PERF_WIDTH = 16,
    localparam int unsigned IW = $clog2(N_INPUTS),
    localparam int unsigned RW = $clog2(N_NEURONS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run_start,
    output logic                  busy,
    output logic                  done,
    input  logic                  wgt_wr_req,
    input  logic [WGT_WIDTH-1:0]  wgt_wr_data,
    input  logic [RW-1:0]         wgt_wr_row,
    input  logic [IW-1:0]         wgt_wr_col,
    output logic                  wgt_wr_ready,
    output logic [IW-1:0]         in_rd_addr,
    output logic                  layer_wr_en,
    output logic [WGT_WIDTH-1:0]  layer_wr_weight,
    output logic [RW-1:0]         layer_wr_row,
    output logic [IW-1:0]         layer_wr_col,
    output logic [IW-1:0]         layer_input_index,
    output logic                  layer_start,
    output logic                  layer_valid,
    output logic                  layer_relu_en,
    output logic [PERF_WIDTH-1:0] perf_cycles,
    output logic [PERF_WIDTH-1:0] perf_runs
);

    localparam logic [IW-1:0] LastIdx = IW'(N_INPUTS - 1);

    typedef enum logic [2:0] {
        StIdle, StClear, StIssue, StDrain, StRelu, StDone
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] addr_q, addr_d;
    logic          busy_q, done_q, start_q, valid_q, relu_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle:  if (run_start) state_d = StClear;
            StClear: begin
                state_d = StIssue;
                addr_d  = '0;
            end
            // Address stops at the last input; no wrap.
            StIssue: begin
                if (addr_q == LastIdx) state_d = StDrain;
                else                   addr_d  = addr_q + IW'(1);
            end
            StDrain: state_d = StRelu;
            StRelu:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes are registered from the next state, so each one is aligned with
    // the state it belongs to. valid trails ISSUE by one cycle to match the
    // 1-cycle read latency of the input buffer and weight memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
            relu_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StDone);
            start_q <= (state_d == StClear);
            valid_q <= (state_q == StIssue);
            relu_q  <= (state_d == StRelu);
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign layer_start       = start_q;
    assign layer_valid       = valid_q;
    assign layer_relu_en     = relu_q;
    assign in_rd_addr        = addr_q;
    assign layer_input_index = addr_q;

    assign wgt_wr_ready    = (state_q == StIdle);
    assign layer_wr_en     = wgt_wr_req & wgt_wr_ready;
    assign layer_wr_weight = wgt_wr_data;
    assign layer_wr_row    = wgt_wr_row;
    assign layer_wr_col    = wgt_wr_col;

`ifdef MLP_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] cyc_q, cyc_d, pcyc_q, pcyc_d, pruns_q, pruns_d;

    always_comb begin
        cyc_d   = cyc_q;
        pcyc_d  = pcyc_q;
        pruns_d = pruns_q;
        // cyc_q holds the 1-based index of the current busy cycle.
        if (state_d == StClear)      cyc_d = PERF_WIDTH'(1);
        else if (state_q != StIdle)  cyc_d = cyc_q + PERF_WIDTH'(1);
        if (state_d == StDone) begin
            pcyc_d = cyc_q + PERF_WIDTH'(1);
            if (pruns_q != '1) pruns_d = pruns_q + PERF_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            pcyc_q  <= '0;
            pruns_q <= '0;
        end else begin
            cyc_q   <= cyc_d;
            pcyc_q  <= pcyc_d;
            pruns_q <= pruns_d;
        end
    end

    assign perf_cycles = pcyc_q;
    assign perf_runs   = pruns_q;
`else
    assign perf_cycles = '0;
    assign perf_runs   = '0;
`endif

endmodule

// File: tb/tb_mlp_layer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mlp_layer_ctrl
//   Self-checking bench for mlp_layer_ctrl (N_INPUTS=2, N_NEURONS=4). A small
//   behavioural layer (weight memory, input buffer, accumulators, ReLU) is
//   driven by the DUT strobes. Expected done cycles are queued when runs are
//   launched and are popped when done is observed.
// ----------------------------------------------------------------------------
module tb_mlp_layer_ctrl;

    localparam int unsigned NI = 2;
    localparam int unsigned NN = 4;
    localparam int unsigned WW = 16;
    localparam int unsigned PW = 16;
    localparam int unsigned IW = $clog2(NI);
    localparam int unsigned RW = $clog2(NN);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run_start = 1'b0;
    logic          busy, done;
    logic          wgt_wr_req = 1'b0;
    logic [WW-1:0] wgt_wr_data = '0;
    logic [RW-1:0] wgt_wr_row = '0;
    logic [IW-1:0] wgt_wr_col = '0;
    logic          wgt_wr_ready;
    logic [IW-1:0] in_rd_addr;
    logic          layer_wr_en;
    logic [WW-1:0] layer_wr_weight;
    logic [RW-1:0] layer_wr_row;
    logic [IW-1:0] layer_wr_col;
    logic [IW-1:0] layer_input_index;
    logic          layer_start, layer_valid, layer_relu_en;
    logic [PW-1:0] perf_cycles, perf_runs;

    mlp_layer_ctrl #(
        .N_INPUTS  (NI),
        .N_NEURONS (NN),
        .WGT_WIDTH (WW),
        .PERF_WIDTH(PW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .run_start        (run_start),
        .busy             (busy),
        .done             (done),
        .wgt_wr_req       (wgt_wr_req),
        .wgt_wr_data      (wgt_wr_data),
        .wgt_wr_row       (wgt_wr_row),
        .wgt_wr_col       (wgt_wr_col),
        .wgt_wr_ready     (wgt_wr_ready),
        .in_rd_addr       (in_rd_addr),
        .layer_wr_en      (layer_wr_en),
        .layer_wr_weight  (layer_wr_weight),
        .layer_wr_row     (layer_wr_row),
        .layer_wr_col     (layer_wr_col),
        .layer_input_index(layer_input_index),
        .layer_start      (layer_start),
        .layer_valid      (layer_valid),
        .layer_relu_en    (layer_relu_en),
        .perf_cycles      (perf_cycles),
        .perf_runs        (perf_runs)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned runs_since_rst = 0;
    int unsigned sb[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural layer driven by the controller strobes.
    logic signed [WW-1:0] w [NN][NI];
    logic signed [WW-1:0] ibuf [NI];
    logic signed [WW-1:0] in_data_q;
    logic signed [WW-1:0] wq [NN];
    logic signed [31:0]   acc [NN];
    logic signed [31:0]   outv [NN];

    always @(posedge clk) begin
        if (layer_wr_en) w[layer_wr_row][layer_wr_col] <= layer_wr_weight;
        in_data_q <= ibuf[in_rd_addr];
        for (int n = 0; n < NN; n++) begin
            wq[n] <= w[n][layer_input_index];
            if (layer_start)        acc[n] <= 0;
            else if (layer_valid)   acc[n] <= acc[n] + wq[n] * in_data_q;
            if (layer_relu_en)      outv[n] <= (acc[n] < 0) ? 0 : acc[n];
        end
    end

    // Done scoreboard and per-cycle invariants.
    always @(negedge clk) begin
        if (!rst) begin
            check_val("strobe_excl",
                      32'(layer_start) + 32'(layer_valid) + 32'(layer_relu_en) <= 1, 1);
            if (wgt_wr_req && !wgt_wr_ready) check_val("wr_gated", layer_wr_en, 0);
            if (done) begin
                if (sb.size() == 0) begin
                    check_val("done_spurious", done, 0);
                end else begin
                    check_val("done_cycle", cyc, sb.pop_front());
                    runs_since_rst++;
                end
            end
        end
    end

    // Launch a run; the returned position is inside C1.
    task automatic start_run(input bit push, input bit wr);
        @(negedge clk);
        run_start = 1'b1;
        if (wr) begin
            wgt_wr_req  = 1'b1;
            wgt_wr_row  = '0;
            wgt_wr_col  = '0;
            wgt_wr_data = WW'(1);
            #1 check_val("wr_with_start", layer_wr_en, 1);
        end
        @(posedge clk);
        #1;
        if (push) sb.push_back(cyc + 5);
        run_start = 1'b0;
    endtask

    task automatic trace_run(input bit wr_held);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check_val("start", layer_start, c == 1);
            check_val("valid", layer_valid, (c == 3) || (c == 4));
            check_val("relu_en", layer_relu_en, c == 5);
            check_val("done", done, c == 6);
            check_val("busy", busy, c <= 6);
            check_val("ready", wgt_wr_ready, c == 7);
            check_val("wr_en", layer_wr_en, (c == 7) && wr_held);
            if (c == 2 || c == 3) begin
                check_val("rd_addr", in_rd_addr, c - 2);
                check_val("index", layer_input_index, c - 2);
            end
            if (c == 6) begin
                for (int n = 0; n < NN; n++) check_val("out", outv[n], 3 * (n + 1) - 2);
            end
        end
    endtask

    task automatic check_perf(input int unsigned exp_cycles, input int unsigned exp_runs);
`ifdef MLP_CTRL_PERF_EN
        check_val("perf_cycles", perf_cycles, exp_cycles);
        check_val("perf_runs", perf_runs, exp_runs);
`else
        check_val("perf_cycles", perf_cycles, 0);
        check_val("perf_runs", perf_runs, 0);
        if (exp_cycles == 0 && exp_runs == 0) ;
`endif
    endtask

    initial begin
        ibuf[0] = 16'sd3;
        ibuf[1] = -16'sd2;
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_start", layer_start, 0);
        check_val("rst_valid", layer_valid, 0);
        check_val("rst_relu", layer_relu_en, 0);
        check_val("rst_addr", in_rd_addr, 0);
        check_val("rst_ready", wgt_wr_ready, 1);
        check_perf(0, 0);
        rst = 1'b0;

        // Weights row n = {n+1, 1}.
        for (int n = 0; n < NN; n++) begin
            for (int i = 0; i < NI; i++) begin
                @(negedge clk);
                wgt_wr_req  = 1'b1;
                wgt_wr_row  = RW'(n);
                wgt_wr_col  = IW'(i);
                wgt_wr_data = (i == 0) ? WW'(n + 1) : WW'(1);
                #1 check_val("load_wr_en", layer_wr_en, 1);
            end
        end
        @(negedge clk);
        wgt_wr_req = 1'b0;

        // Nominal run with full strobe trace and layer result.
        start_run(1, 0);
        trace_run(0);
        check_perf(NI + 4, 1);

        // Weight write held across a run (same value, so results unchanged).
        start_run(1, 1);
        trace_run(1);
        wgt_wr_req = 1'b0;

        // run_start pulsed mid-run is ignored.
        start_run(1, 0);
        repeat (2) @(negedge clk);
        @(negedge clk);
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        repeat (8) @(negedge clk);

        // run_start held: back-to-back runs every NI+5 cycles.
        @(negedge clk);
        run_start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(cyc + 5);
        sb.push_back(cyc + 12);
        sb.push_back(cyc + 19);
        repeat (20) @(negedge clk);
        run_start = 1'b0;
        repeat (10) @(negedge clk);
        check_perf(NI + 4, 6);

        // Reset asserted mid-ISSUE: abort, no done.
        start_run(0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_start", layer_start, 0);
        check_val("abort_valid", layer_valid, 0);
        check_val("abort_relu", layer_relu_en, 0);
        check_val("abort_ready", wgt_wr_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        runs_since_rst = 0;
        check_perf(0, 0);
        repeat (10) @(negedge clk);

        // Recovery run after abort.
        start_run(1, 0);
        trace_run(0);
        check_perf(NI + 4, 1);
        check_val("runs_after_rst", runs_since_rst, 1);

        check_val("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
